// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter: FSM state encodings and parity modes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_pkg;

  // FSM state encoding, kept as plain constants so legacy tools can consume it
  localparam int unsigned STATE_W   = 3;
  localparam logic [2:0]  ST_IDLE   = 3'd0;
  localparam logic [2:0]  ST_START  = 3'd1;
  localparam logic [2:0]  ST_DATA   = 3'd2;
  localparam logic [2:0]  ST_PARITY = 3'd3;
  localparam logic [2:0]  ST_STOP   = 3'd4;

  // Parity mode: value XORed onto the even parity of the data bits
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Width of the bit index used for data bits (up to 9) and stop bits (up to 2)
  localparam int unsigned BIT_IDX_W = 4;

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period timer: counts clock cycles and pulses tick on the last cycle of each bit period.
// Latency: tick is combinational from the count; count restarts the cycle after clear or tick.
// Backpressure: none; clear has priority and holds the count at zero.
module baud_cnt #(
  parameter int unsigned DIV = 868
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;
  logic         w_tick;

  assign w_tick = (r_cnt == LAST);
  assign tick_o = w_tick;

  // Count cycles within the bit period, wrapping to zero on tick or clear
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clear_i || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops words from a first-word-fall-through FIFO and serialises start/data/parity/stop.
// Latency: start bit appears on tx_o the cycle after the pop; frame is (1+B+PAR_EN+SB)*DIV cycles.
// Backpressure: pops only when idle (or on the last stop cycle) and the FIFO is non-empty, once per frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned B       = 8,
  parameter int unsigned DIV     = 868,
  parameter int unsigned PAR_EN  = 0,
  parameter int unsigned PAR_ODD = 0,
  parameter int unsigned SB      = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         fifo_empty_i,
  input  logic [B-1:0] fifo_data_bi,
  output logic         fifo_rd_o,
  output logic         tx_o,
  output logic         busy_o
);

  localparam logic [BIT_IDX_W-1:0] LAST_DATA = BIT_IDX_W'(B - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_STOP = BIT_IDX_W'(SB - 1);
  localparam logic                 PAR_MODE  = (PAR_ODD != 0) ? PARITY_ODD : PARITY_EVEN;

  logic [STATE_W-1:0]   r_state;
  logic [BIT_IDX_W-1:0] r_bit;
  logic [B-1:0]         r_shift;
  logic                 r_par;
  logic                 r_tx;

  logic                 w_tick;
  logic                 w_pop;
  logic [STATE_W-1:0]   w_state_nxt;
  logic [BIT_IDX_W-1:0] w_bit_nxt;
  logic [B-1:0]         w_shift_nxt;
  logic                 w_tx_nxt;

  // The counter is held at zero while idle, so START always gets a full period;
  // every later state entry coincides with a tick, which wraps the count itself.
  baud_cnt #(
    .DIV (DIV)
  ) u_baud_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (r_state == ST_IDLE),
    .tick_o  (w_tick)
  );

  // Next-state, bit index, shift register and pop decision
  always_comb begin
    w_pop       = 1'b0;
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    case (r_state)
      ST_IDLE: begin
        if (!fifo_empty_i) w_pop = 1'b1;
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit == LAST_DATA) begin
            w_bit_nxt   = '0;
            w_state_nxt = (PAR_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_nxt = r_bit + BIT_IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_state_nxt = ST_STOP;
          w_bit_nxt   = '0;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_bit == LAST_STOP) begin
            w_bit_nxt = '0;
            // Gapless chaining: a waiting word starts its frame right away
            if (!fifo_empty_i) w_pop = 1'b1;
            else               w_state_nxt = ST_IDLE;
          end else begin
            w_bit_nxt = r_bit + BIT_IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_pop) begin
      w_state_nxt = ST_START;
      w_shift_nxt = fifo_data_bi;
      w_bit_nxt   = '0;
    end
  end

  // Line level for the coming cycle, derived from where the FSM is heading
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_shift_nxt[0];
      ST_PARITY: w_tx_nxt = r_par;
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  // State, datapath and registered line output
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      if (w_pop) r_par <= (^fifo_data_bi) ^ PAR_MODE;
    end
  end

  // Reset gates the pop so a held-off FIFO is never drained while in reset
  assign fifo_rd_o = w_pop & rst_ni;
  assign tx_o      = r_tx;
  assign busy_o    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: four DIV=4, B=8 instances (plain, even parity, odd parity, two stop bits).
// Each instance is fed by a small FIFO model; line bits are sampled mid-bit and compared to hand-built strings.
// Data seen by the DUT while its FIFO is empty changes every cycle.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       emp [4];
  logic [7:0] dat [4];
  logic       rd  [4];
  logic       tx  [4];
  logic       bsy [4];

  logic [7:0] mem [4][16];
  logic [3:0] wp  [4] = '{default: 4'd0};
  logic [3:0] rp  [4] = '{default: 4'd0};
  logic [7:0] junk    = 8'h00;
  int         bad_pop = 0;
  int         checks  = 0;
  int         errors  = 0;

  for (genvar g = 0; g < 4; g++) begin : g_fifo
    assign emp[g] = (wp[g] == rp[g]);
    assign dat[g] = emp[g] ? junk : mem[g][rp[g]];
  end

  always @(posedge clk) begin
    junk <= 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      if (rd[i]) begin
        if (emp[i]) bad_pop++;
        else        rp[i] <= rp[i] + 4'd1;
      end
    end
  end

  uart_tx #(.B(8), .DIV(4), .PAR_EN(0), .PAR_ODD(0), .SB(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .fifo_empty_i(emp[0]), .fifo_data_bi(dat[0]),
    .fifo_rd_o(rd[0]), .tx_o(tx[0]), .busy_o(bsy[0]));
  uart_tx #(.B(8), .DIV(4), .PAR_EN(1), .PAR_ODD(0), .SB(1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .fifo_empty_i(emp[1]), .fifo_data_bi(dat[1]),
    .fifo_rd_o(rd[1]), .tx_o(tx[1]), .busy_o(bsy[1]));
  uart_tx #(.B(8), .DIV(4), .PAR_EN(1), .PAR_ODD(1), .SB(1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .fifo_empty_i(emp[2]), .fifo_data_bi(dat[2]),
    .fifo_rd_o(rd[2]), .tx_o(tx[2]), .busy_o(bsy[2]));
  uart_tx #(.B(8), .DIV(4), .PAR_EN(0), .PAR_ODD(0), .SB(2)) u_d (
    .clk_i(clk), .rst_ni(rst_n), .fifo_empty_i(emp[3]), .fifo_data_bi(dat[3]),
    .fifo_rd_o(rd[3]), .tx_o(tx[3]), .busy_o(bsy[3]));

  typedef struct {
    string      name;
    int         inst;
    logic [7:0] data;
    string      bits;   // line order: start, data LSB first, parity, stop(s)
    int         len;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_s(input string name, input string got, input string exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %s, expected %s", name, got, exp);
    end
  endtask

  task automatic push(input int inst, input logic [7:0] d);
    mem[inst][wp[inst]] = d;
    wp[inst] = wp[inst] + 4'd1;
  endtask

  // Returns at the pop cycle (between its falling and rising edges) or after 50 cycles
  task automatic wait_pop(input int inst, output bit ok);
    #1;
    for (int w = 0; w < 50 && !rd[inst]; w++) begin
      @(negedge clk);
      #1;
    end
    ok = rd[inst];
  endtask

  task automatic run_frames(input string name, input int inst, input string exp,
                            input int len, input int npops);
    bit    ok;
    string got;
    int    bcnt;
    int    pops;
    wait_pop(inst, ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_pop: no pop within 50 cycles, expected one", name);
      return;
    end
    got  = "";
    bcnt = 0;
    pops = 1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (!bsy[inst]) break;
      bcnt++;
      if (rd[inst]) pops++;
      if (n >= 2 && (n - 2) % 4 == 0 && got.len() < exp.len())
        got = {got, tx[inst] ? "1" : "0"};
    end
    chk_s({name, "_bits"}, got, exp);
    chk({name, "_busy_cycles"}, bcnt, len);
    chk({name, "_pops"}, pops, npops);
    chk({name, "_idle_tx"}, int'(tx[inst]), 1);
  endtask

  initial begin
    bit ok;
    int bad;

    vecs[0] = '{"a5_plain",  0, 8'hA5, "0101001011",  40};
    vecs[1] = '{"00_plain",  0, 8'h00, "0000000001",  40};
    vecs[2] = '{"ff_plain",  0, 8'hFF, "0111111111",  40};
    vecs[3] = '{"a5_even",   1, 8'hA5, "01010010101", 44};
    vecs[4] = '{"a5_odd",    2, 8'hA5, "01010010111", 44};
    vecs[5] = '{"07_even",   1, 8'h07, "01110000011", 44};
    vecs[6] = '{"3c_2stop",  3, 8'h3C, "00011110011", 44};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx%0d", i), int'(tx[i]), 1);
      chk($sformatf("rst_busy%0d", i), int'(bsy[i]), 0);
    end
    chk("rst_rd0", int'(rd[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty FIFO for 100 cycles: line idle, no pops
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (rd[i] || !tx[i] || bsy[i]) bad++;
    end
    chk("idle_100", bad, 0);

    // Single frames across the configurations
    for (int v = 0; v < 7; v++) begin
      push(vecs[v].inst, vecs[v].data);
      run_frames(vecs[v].name, vecs[v].inst, vecs[v].bits, vecs[v].len, 1);
    end

    // Three queued words go out back to back with no idle gap
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    run_frames("b2b", 0, {"0000000001", "0111111111", "0001111001"}, 120, 3);

    // Reset in the 13th cycle of a frame, with a new word already waiting
    push(0, 8'hA5);
    wait_pop(0, ok);
    chk("mid_rst_first_pop", int'(ok), 1);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    push(0, 8'h55);
    #1;
    chk("mid_rst_rd_before_edge", int'(rd[0]), 0);
    @(negedge clk);
    chk("mid_rst_tx", int'(tx[0]), 1);
    chk("mid_rst_busy", int'(bsy[0]), 0);
    chk("mid_rst_rd_in_reset", int'(rd[0]), 0);
    rst_n = 1'b1;
    run_frames("rst_recover", 0, "0101010101", 40, 1);

    chk("pop_while_empty", bad_pop, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter B, default 8, data bits per frame (5..9).
REQ-002 Parameter DIV, default 868, clock cycles per bit period (>=2).
REQ-003 Parameter PAR_EN, default 0, 1 = parity bit appended after data.
REQ-004 Parameter PAR_ODD, default 0, 1 = odd parity, 0 = even; ignored when PAR_EN=0.
REQ-005 Parameter SB, default 1, stop bits (1 or 2).
REQ-006 clk_i  input  1  sole clock, all logic on rising edge.
REQ-007 rst_ni  input  1  reset, synchronous, active-low.
REQ-008 fifo_empty_i  input  1  upstream FIFO empty flag.
REQ-009 fifo_data_bi  input  B  upstream FIFO head word, valid whenever fifo_empty_i=0 (first-word-fall-through).
REQ-010 fifo_rd_o  output  1  one-cycle pop strobe to upstream FIFO.
REQ-011 tx_o  output  1  serial line, idle high.
REQ-012 busy_o  output  1  frame in progress.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-014 In IDLE with fifo_empty_i=0, the block SHALL assert fifo_rd_o for exactly that cycle, latch fifo_data_bi into a shift register, and enter START next cycle.
REQ-015 fifo_rd_o SHALL never be asserted while fifo_empty_i=1, and SHALL be asserted at most once per frame.
REQ-016 Each state's bit SHALL be held on tx_o for exactly DIV cycles, timed by a bit counter cleared on every state entry and on every bit advance, tick at count DIV-1.
REQ-017 START drives tx_o=0; DATA drives B bits LSB first; PARITY (only if PAR_EN=1) drives XOR of the data bits, inverted when PAR_ODD=1; STOP drives tx_o=1 for SB bit periods.
REQ-018 tx_o SHALL be registered; tx_o=1 in IDLE.
REQ-019 Transitions: START->DATA after 1 period; DATA->PARITY (PAR_EN=1) or STOP after B periods; PARITY->STOP after 1 period.
REQ-020 On the last cycle of STOP: if fifo_empty_i=0, pop (per REQ-014) and enter START directly (gapless back-to-back frames); otherwise enter IDLE.
REQ-021 Frame length SHALL be (1+B+PAR_EN+SB)*DIV cycles; first start bit appears on tx_o in the cycle after the pop.
REQ-022 busy_o SHALL be high in START, DATA, PARITY, STOP and low in IDLE.
REQ-023 fifo_empty_i/fifo_data_bi changes during a frame SHALL not affect the frame in flight.

Reset
REQ-024 With rst_ni=0 at a rising edge: state=IDLE, tx_o=1, fifo_rd_o=0, busy_o=0, counters and shift register zeroed.
REQ-025 Reset mid-frame SHALL abandon the frame (tx_o=1 next cycle) with no pop issued during or in the cycle reset is asserted.

Structure
REQ-026 State encoding constants and parity-mode constants SHALL reside in a shared package uart_pkg.
REQ-027 Bit-period counter SHALL be one sub-module, baud_cnt (inputs clear, output tick; width $clog2(DIV)).
REQ-028 No other sub-modules; pops interface directly to the existing fifo block (rd_i/empty_o/r_data_bo).

Verification
REQ-029 DIV=4, B=8, PAR_EN=0, SB=1, push 0xA5 -> one fifo_rd_o pulse; tx_o sampled every 4 cycles = 0,1,0,1,0,0,1,0,1,1; busy_o high 40 cycles.
REQ-030 PAR_EN=1, PAR_ODD=0, data 0xA5 -> parity bit 0; PAR_ODD=1 -> parity bit 1; frame 44 cycles at DIV=4.
REQ-031 Push 0x00,0xFF,0x3C before release from idle -> three frames contiguous, no idle cycle between stop and next start, exactly three pops, busy_o continuously high 120 cycles.
REQ-032 FIFO kept empty for 100 cycles -> fifo_rd_o never asserted, tx_o=1, busy_o=0.
REQ-033 rst_ni=0 at cycle 13 of a DIV=4 frame -> tx_o=1 and busy_o=0 next cycle, no pop; after release with FIFO holding 0x55, fresh full frame 0x55 transmitted.
REQ-034 SB=2, DIV=4 -> stop high 8 cycles, frame 44 cycles; fifo_data_bi changed mid-frame -> transmitted bits unchanged.
